uart_rx_deser_gen2: RTL
=======================

Name: uart_rx_deser_gen2

Overview:
Parametrised successor to the UART RX bit deserializer. It collects sampled serial bits into a word of runtime-selectable length (MIN_LEN..DATA_WIDTH) in either bit order, and keeps its own bit counter instead of indexing by an external count. It publishes a completed, right-justified word with a one-cycle valid pulse. It sits between the RX data-sampling stage and the RX FSM/parity/stop checkers.

Parameters:
DATA_WIDTH, 8, maximum word length in bits (2..16)
MIN_LEN, 5, minimum legal runtime word length
LEN_W, 5, width of Data_len and Bit_idx; must hold DATA_WIDTH

Ports:
CLK  input  1  system clock; the block uses one clock only
RST  input  1  reset is synchronous and active-high
Enable  input  1  bit strobe: Sampled_bit is valid this cycle
Clear  input  1  abort the current word and restart at bit 0
Sampled_bit  input  1  majority-voted serial bit
Data_len  input  LEN_W  word length; captured at the first bit of each word
Msb_first  input  1  0 = LSB first (UART default), 1 = MSB first; captured with Data_len
P_data  output  DATA_WIDTH  last completed word, right-justified, upper bits zero
Data_valid  output  1  one-cycle pulse when P_data updates
Busy  output  1  high while a word is partially received
Bit_idx  output  LEN_W  number of bits received in the current word

Behaviour:
- Reset (RST=1 at a CLK edge): P_data=0, Data_valid=0, Busy=0, Bit_idx=0, shift register=0, captured len=DATA_WIDTH, captured order=0.
- States: IDLE (Bit_idx=0), SHIFT (0<Bit_idx<len). Busy = (state==SHIFT).
- IDLE with Enable: capture Data_len and Msb_first.
  - Clamp length: values <MIN_LEN become MIN_LEN; values >DATA_WIDTH become DATA_WIDTH.
  - Store the bit and set Bit_idx=1, then go to SHIFT.
  - If the clamped length is 1, this bit completes the word (unreachable when MIN_LEN≥2).
- Bit store rules:
  - LSB-first: bit k lands at position k.
  - MSB-first: shift register shifts left, new bit enters at the LSB.
- Completion: when an Enable arrives with Bit_idx==len-1, the word is complete. On the next edge:
  - P_data takes the assembled word, bits [len-1:0] valid, upper bits 0.
  - Data_valid=1 for exactly one cycle.
  - Bit_idx=0, state goes to IDLE.
- Latency: the last Enable bit appears in P_data with Data_valid one cycle later.
- Back-to-back: an Enable in the cycle where Data_valid is high starts a new word normally. No bits are lost.
- Enable=0: the block holds all state. Data_valid is 0 in every cycle except completion pulses.
- Clear: Bit_idx=0, state goes to IDLE, shift register is zeroed. P_data is unchanged. No Data_valid.
  - Clear and Enable in the same cycle: Clear wins and the bit is dropped.
  - Clear on the completing Enable: the word is dropped with no pulse.
- RST has priority over Clear. Reset in the middle of a word discards it.
- Data_len and Msb_first changes during SHIFT are ignored until the next word.

Optional Feature:
Macro: UART_RX_DESER_PARITY_EN.
- Defined:
  - Adds output Par_calc (1 bit). It holds the XOR of all bits of the last completed word and updates together with P_data.
  - Reset value is 0. Clear leaves it unchanged.
  - The running parity accumulator resets with Clear/RST.
- Not defined: the port and the accumulator are absent. All other behaviour is identical.

Decomposition:
- Shared package uart_rx_pkg holds:
  - DATA_WIDTH_MAX=16
  - MIN_LEN default
  - LEN_W derivation function (clog2(DATA_WIDTH+1))
  - bit-order enum {ORDER_LSB=0, ORDER_MSB=1}
- One sub-module is natural: uart_rx_len_clamp, a combinational clamp of Data_len to [MIN_LEN, DATA_WIDTH].
- Everything else stays in one module.

Test Plan:
- Reset, then LSB-first, len=8, bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) → P_data=0xA5, Data_valid pulse 1 cycle after the 8th Enable, Busy high from the 1st to the 8th bit.
- Msb_first=1, len=8, bits 1,0,1,0,0,1,0,1 → P_data=0xA5. With Msb_first=0 the same bits give 0xA5 reversed = 0xA5. Repeat with bits 1,1,0,0,0,0,0,0 → MSB-first 0xC0, LSB-first 0x03.
- len=5, LSB-first, bits 1,1,1,1,1 → P_data=0x1F. Data_len=3 → clamped to 5. Data_len=12 with DATA_WIDTH=8 → clamped to 8.
- Two back-to-back 8-bit words 0x3C, 0xC3 with Enable every cycle → two Data_valid pulses 8 cycles apart, P_data=0x3C then 0xC3.
- After 4 bits assert Clear together with Enable → Bit_idx=0, Busy=0, P_data keeps its old value, no pulse. A following full word 0x55 is received correctly.
- RST pulse in the middle of a word at bit 6 → all outputs return to reset values. Under UART_RX_DESER_PARITY_EN, word 0x07 gives Par_calc=1 and 0x03 gives Par_calc=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
//------------------------------------------------------------------------------
// uart_rx_pkg : shared types and constants for the UART RX deserializer family
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_rx_pkg;

  localparam int DATA_WIDTH_MAX = 16;
  localparam int MIN_LEN_DEF    = 5;

  function automatic int len_w_calc(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  typedef enum logic {
    ORDER_LSB = 1'b0,
    ORDER_MSB = 1'b1
  } bit_order_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_len_clamp.sv
//------------------------------------------------------------------------------
// uart_rx_len_clamp : limits a requested word length to [MIN_LEN, DATA_WIDTH]
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_len_clamp
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN    = MIN_LEN_DEF,
  parameter int LEN_W      = 5
) (
  input  logic [LEN_W-1:0] len_in,
  output logic [LEN_W-1:0] len_out
);

  always_comb begin
    if (len_in < LEN_W'(MIN_LEN)) begin
      len_out = LEN_W'(MIN_LEN);
    end else if (len_in > LEN_W'(DATA_WIDTH)) begin
      len_out = LEN_W'(DATA_WIDTH);
    end else begin
      len_out = len_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_deser_gen2.sv
//------------------------------------------------------------------------------
// uart_rx_deser_gen2 : runtime-length, either-order serial-to-parallel word
// assembler. Optional Par_calc output under UART_RX_DESER_PARITY_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_deser_gen2
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN    = MIN_LEN_DEF,
  parameter int LEN_W      = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Enable,
  input  logic                  Clear,
  input  logic                  Sampled_bit,
  input  logic [LEN_W-1:0]      Data_len,
  input  logic                  Msb_first,
  output logic [DATA_WIDTH-1:0] P_data,
  output logic                  Data_valid,
  output logic                  Busy,
  output logic [LEN_W-1:0]      Bit_idx
`ifdef UART_RX_DESER_PARITY_EN
  ,
  output logic                  Par_calc
`endif
);

  rx_state_e             state_q, state_d;
  logic [LEN_W-1:0]      bit_idx_q, bit_idx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  bit_order_e            order_q, order_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic [LEN_W-1:0]      clamped_len;
  logic [LEN_W-1:0]      eff_len;
  bit_order_e            eff_order;
  logic [DATA_WIDTH-1:0] word_nxt;
`ifdef UART_RX_DESER_PARITY_EN
  logic                  par_acc_q, par_acc_d;
  logic                  par_q, par_d;
`endif

  uart_rx_len_clamp #(
    .DATA_WIDTH (DATA_WIDTH),
    .MIN_LEN    (MIN_LEN),
    .LEN_W      (LEN_W)
  ) u_len_clamp (
    .len_in  (Data_len),
    .len_out (clamped_len)
  );

  // Shift register is zero whenever idle, so both orders start from a clean word
  always_comb begin
    eff_len   = (state_q == ST_IDLE) ? clamped_len : len_q;
    eff_order = (state_q == ST_IDLE) ? bit_order_e'(Msb_first) : order_q;
    if (eff_order == ORDER_MSB) begin
      word_nxt = {shreg_q[DATA_WIDTH-2:0], Sampled_bit};
    end else begin
      word_nxt = shreg_q | (DATA_WIDTH'(Sampled_bit) << bit_idx_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    len_d        = len_q;
    order_d      = order_q;
    shreg_d      = shreg_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
    par_acc_d    = par_acc_q;
    par_d        = par_q;
`endif
    if (Clear) begin
      state_d   = ST_IDLE;
      bit_idx_d = '0;
      shreg_d   = '0;
`ifdef UART_RX_DESER_PARITY_EN
      par_acc_d = 1'b0;
`endif
    end else if (Enable) begin
      len_d   = eff_len;
      order_d = eff_order;
      if (bit_idx_q == eff_len - LEN_W'(1)) begin
        p_data_d     = word_nxt;
        data_valid_d = 1'b1;
        state_d      = ST_IDLE;
        bit_idx_d    = '0;
        shreg_d      = '0;
`ifdef UART_RX_DESER_PARITY_EN
        par_d        = par_acc_q ^ Sampled_bit;
        par_acc_d    = 1'b0;
`endif
      end else begin
        state_d   = ST_SHIFT;
        bit_idx_d = bit_idx_q + LEN_W'(1);
        shreg_d   = word_nxt;
`ifdef UART_RX_DESER_PARITY_EN
        par_acc_d = par_acc_q ^ Sampled_bit;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      len_q        <= LEN_W'(DATA_WIDTH);
      order_q      <= ORDER_LSB;
      shreg_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
      par_acc_q    <= 1'b0;
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      len_q        <= len_d;
      order_q      <= order_d;
      shreg_q      <= shreg_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
`ifdef UART_RX_DESER_PARITY_EN
      par_acc_q    <= par_acc_d;
      par_q        <= par_d;
`endif
    end
  end

  assign P_data     = p_data_q;
  assign Data_valid = data_valid_q;
  assign Busy       = (state_q == ST_SHIFT);
  assign Bit_idx    = bit_idx_q;
`ifdef UART_RX_DESER_PARITY_EN
  assign Par_calc   = par_q;
`endif

endmodule

`default_nettype wire
